// File: rtl/loader_pkg.sv
// Shared types and constants for the MC14500B program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    CMD,
    WRITE,
    SUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;

  // Bytes needed to carry a command of the given bit width.
  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/cmd_assembler.sv
// Collects BYTES stream bytes (LSB first) into one command word and flags
// completion and out-of-range high bits on the byte that finishes the word.
module cmd_assembler
  import loader_pkg::*;
#(
  parameter int WORD  = 12,
  parameter int BYTES = bytes_for(WORD)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            byte_en,
  input  logic [7:0]      byte_data,
  output logic            complete,
  output logic            overflow,
  output logic [WORD-1:0] word
);

  localparam int SHIFT_W = BYTES * 8;
  localparam int CNT_W   = $clog2(BYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (byte_en) begin
      shift_d  = (shift_q >> 8) | (SHIFT_W'(byte_data) << (SHIFT_W - 8));
      complete = (cnt_q == LAST);
      cnt_d    = complete ? '0 : cnt_q + 1'b1;
    end
  end

  assign word     = shift_d[WORD-1:0];
  assign overflow = complete && (|(shift_d >> WORD));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // NOTE: the shift register is pure datapath and is fully overwritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes commands into text RAM from address 0 and
// keeps the CPU held until the whole frame's checksum verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR = 8,
  parameter int CODE = 4,
  parameter int WORD = ADDR + CODE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            prog_write,
  output logic [ADDR-1:0] prog_addr,
  output logic [WORD-1:0] prog_cmd,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR:0]   loaded_count
);

  localparam int BYTES = bytes_for(WORD);

  loader_state_t   state_q, state_d;
  logic [7:0]      csum_q, csum_d;
  logic [ADDR:0]   count_q, count_d;
  logic [ADDR:0]   len_q, len_d;
  logic            hold_q, hold_d;
  logic            write_q, write_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [WORD-1:0] cmd_q, cmd_d;

  logic            accept;
  logic            len_bad;
  logic            asm_done;
  logic            asm_ovf;
  logic [WORD-1:0] asm_word;

  assign in_ready = !(state_q inside {WRITE, DONE, ERR});
  assign accept   = in_valid && in_ready;
  assign len_bad  = (in_data == 8'd0) || (32'(in_data) > (32'd1 << ADDR));

  cmd_assembler #(
    .WORD  (WORD),
    .BYTES (BYTES)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == IDLE),
    .byte_en   (accept && (state_q == CMD)),
    .byte_data (in_data),
    .complete  (asm_done),
    .overflow  (asm_ovf),
    .word      (asm_word)
  );

  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    count_d = count_q;
    len_d   = len_q;
    hold_d  = hold_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      IDLE: begin
        // Mid-frame A5 bytes never reach here, so they are always treated as data.
        if (accept && (in_data == LOADER_HEADER)) begin
          state_d = LEN;
          hold_d  = 1'b1;
          count_d = '0;
          csum_d  = '0;
        end
      end
      LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d = ERR;
          end else begin
            len_d   = (ADDR + 1)'(in_data);
            state_d = CMD;
          end
        end
      end
      CMD: begin
        if (accept) csum_d = csum_q ^ in_data;
        if (asm_done) begin
          if (asm_ovf) begin
            state_d = ERR;
          end else begin
            state_d = WRITE;
            write_d = 1'b1;
            addr_d  = count_q[ADDR-1:0];
            cmd_d   = asm_word;
          end
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        state_d = ((count_q + 1'b1) == len_q) ? SUM : CMD;
      end
      SUM: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      end
      DONE: begin
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      csum_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      hold_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      count_q <= count_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
    end
  end

  assign prog_write   = write_q;
  assign prog_addr    = addr_q;
  assign prog_cmd     = cmd_q;
  assign cpu_hold     = hold_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign loaded_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus random frames,
// compared against a frame-level parser model of the byte stream.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int ADDR  = 8;
  localparam int CODE  = 4;
  localparam int WORD  = ADDR + CODE;
  localparam int BYTES = (WORD + 7) / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            prog_write;
  logic [ADDR-1:0] prog_addr;
  logic [WORD-1:0] prog_cmd;
  logic            cpu_hold;
  logic            done;
  logic            error;
  logic [ADDR:0]   loaded_count;

  program_loader #(.ADDR(ADDR), .CODE(CODE)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .prog_write   (prog_write),
    .prog_addr    (prog_addr),
    .prog_cmd     (prog_cmd),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .loaded_count (loaded_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // kind: 0 write, 1 done, 2 error. 'at' is a byte index (expected) or a cycle (observed).
  typedef struct {
    int kind;
    int at;
    int addr;
    int data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] seg_q[$];
  int         edge_q[$];
  logic       exp_hold;
  int         exp_loaded;
  bit         mon_en    = 1'b0;
  int         hold_rise = -1;
  int         hold_fall = -1;
  logic       hold_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prog_write) obs_q.push_back('{0, cyc, int'(prog_addr), int'(prog_cmd)});
      if (done)       obs_q.push_back('{1, cyc, 0, 0});
      if (error)      obs_q.push_back('{2, cyc, 0, 0});
      check("ready_low_only_in_write_done_err", in_ready, !(prog_write || done || error));
      check("done_error_exclusive", done && error, 1'b0);
      if (cpu_hold && !hold_prev) hold_rise = cyc;
      if (!cpu_hold && hold_prev) hold_fall = cyc;
      hold_prev = cpu_hold;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  // Frame-level reference: walks the byte list the way the frame format is defined.
  task automatic run_model();
    int   i, n, nlen, word;
    logic [7:0] x;
    bit   aborted;
    i = 0;
    n = seg_q.size();
    exp_q.delete();
    while (i < n) begin
      if (seg_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      exp_hold   = 1'b1;
      exp_loaded = 0;
      i++;
      if (i >= n) break;
      nlen = int'(seg_q[i]);
      if (nlen == 0 || nlen > (1 << ADDR)) begin
        exp_q.push_back('{2, i, 0, 0});
        i++;
        continue;
      end
      i++;
      x = 8'h00;
      aborted = 1'b0;
      for (int k = 0; k < nlen; k++) begin
        word = 0;
        for (int j = 0; j < BYTES; j++) begin
          if (i >= n) begin
            aborted = 1'b1;
            break;
          end
          word = word | (int'(seg_q[i]) << (8 * j));
          x    = x ^ seg_q[i];
          i++;
        end
        if (aborted) break;
        if (word >= (1 << WORD)) begin
          exp_q.push_back('{2, i - 1, 0, 0});
          aborted = 1'b1;
          break;
        end
        exp_q.push_back('{0, i - 1, k, word});
        exp_loaded = k + 1;
      end
      if (aborted) continue;
      if (i >= n) break;
      if (seg_q[i] == x) begin
        exp_q.push_back('{1, i, 0, 0});
        exp_hold = 1'b0;
      end else begin
        exp_q.push_back('{2, i, 0, 0});
      end
      i++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic drive_byte(input logic [7:0] b, input int gap, output int edge_no);
    bit got;
    got     = 1'b0;
    edge_no = -1;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 8 && !got; t++) begin
      if (in_ready) begin
        edge_no = cyc + 1;
        got     = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_segment(input string tag);
    check({tag, " event_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < obs_q.size()) begin
        check({tag, " event_kind"}, obs_q[k].kind, exp_q[k].kind);
        check({tag, " event_cycle"}, obs_q[k].at, edge_q[exp_q[k].at]);
        if (exp_q[k].kind == 0) begin
          check({tag, " prog_addr"}, obs_q[k].addr, exp_q[k].addr);
          check({tag, " prog_cmd"}, obs_q[k].data, exp_q[k].data);
        end
      end
    end
    check({tag, " loaded_count"}, loaded_count, exp_loaded);
    check({tag, " cpu_hold"}, cpu_hold, exp_hold);
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random stalls.
  task automatic send_segment(input string tag, input int gap_mode);
    int e, gap;
    run_model();
    obs_q.delete();
    edge_q.delete();
    hold_rise = -1;
    hold_fall = -1;
    foreach (seg_q[k]) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      drive_byte(seg_q[k], gap, e);
      edge_q.push_back(e);
      check({tag, " byte_accepted"}, e >= 0, 1'b1);
    end
    repeat (4) @(negedge clk);
    compare_segment(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " in_ready"}, in_ready, 1'b1);
    check({tag, " prog_write"}, prog_write, 1'b0);
    check({tag, " prog_addr"}, prog_addr, '0);
    check({tag, " prog_cmd"}, prog_cmd, '0);
    check({tag, " cpu_hold"}, cpu_hold, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " error"}, error, 1'b0);
    check({tag, " loaded_count"}, loaded_count, '0);
  endtask

  task automatic build_random_frame();
    int         n, g, w;
    logic [7:0] b, x;
    seg_q.delete();
    g = $urandom_range(0, 2);
    repeat (g) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      seg_q.push_back(b);
    end
    n = $urandom_range(0, 4);
    seg_q.push_back(8'hA5);
    seg_q.push_back(8'(n));
    if (n == 0) return;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = $urandom_range(0, 4095);
      if ($urandom_range(0, 5) == 0) w = (w & 'hF00) | 'hA5;
      if ($urandom_range(0, 9) == 0) w = w | (1 << $urandom_range(12, 15));
      for (int j = 0; j < BYTES; j++) begin
        b = 8'(w >> (8 * j));
        seg_q.push_back(b);
        x = x ^ b;
      end
      if (w > 4095) return;
    end
    b = x;
    if ($urandom_range(0, 4) == 0) b = x ^ 8'(1 << $urandom_range(0, 7));
    seg_q.push_back(b);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    reset      = 1'b0;
    exp_hold   = 1'b0;
    exp_loaded = 0;
    mon_en     = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    seg_q = '{8'hA5, 8'h02, 8'h12, 8'h03, 8'hFF, 8'h0C, 8'hE2};
    send_segment("two_cmd", 0);
    if (obs_q.size() == 3) begin
      check("two_cmd w0_cmd", obs_q[0].data, 32'h312);
      check("two_cmd w1_cmd", obs_q[1].data, 32'hCFF);
      check("two_cmd w1_addr", obs_q[1].addr, 32'd1);
    end
    check("two_cmd hold_rise", hold_rise, edge_q[0]);
    check("two_cmd hold_fall", hold_fall, edge_q[6] + 1);

    seg_q = '{8'hA5, 8'h02, 8'h12, 8'h03, 8'hFF, 8'h0C, 8'hE3};
    send_segment("bad_checksum", 0);
    seg_q = '{8'hA5, 8'h02, 8'h12, 8'h03, 8'hFF, 8'h0C, 8'hE2};
    send_segment("recover_good", 0);

    seg_q = '{8'hA5, 8'h01, 8'h00, 8'h10};
    send_segment("overflow", 0);

    seg_q = '{8'hA5, 8'h00};
    send_segment("zero_length", 0);

    seg_q = '{8'h00, 8'h5A, 8'hA5, 8'h01, 8'h34, 8'h08, 8'h3C};
    send_segment("garbage_stall", 1);
    if (obs_q.size() == 2) check("garbage_stall w0_cmd", obs_q[0].data, 32'h834);

    seg_q = '{8'hA5, 8'h02, 8'h12};
    send_segment("pre_reset", 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_frame_reset");
    reset      = 1'b0;
    exp_hold   = 1'b0;
    exp_loaded = 0;
    @(negedge clk);
    check("mid_frame_reset no_write", obs_q.size(), 0);
    seg_q = '{8'hA5, 8'h02, 8'h12, 8'h03, 8'hFF, 8'h0C, 8'hE2};
    send_segment("post_reset", 0);

    for (int r = 0; r < 30; r++) begin
      build_random_frame();
      send_segment("random", 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Streaming program loader for the MC14500B core. Accepts a framed byte stream over a valid/ready handshake, assembles `WORD`-bit instruction words, and writes them into text RAM at consecutive addresses from 0. The CPU is held off while a load is in progress and is released only after the frame's checksum verifies. It is the write-side counterpart of the text RAM's instruction fetch path.

## Interface
- `ADDR`, 8: text RAM address width; also the operand field width of a command.
- `CODE`, 4: opcode field width.
- `WORD`, `ADDR + CODE`: command width; `BYTES = ceil(WORD/8)` bytes per command.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `in_data`  in  8  stream byte.
- `prog_write`  out  1  one-cycle text RAM write strobe.
- `prog_addr`  out  `ADDR`  write address.
- `prog_cmd`  out  `WORD`  write data.
- `cpu_hold`  out  1  high means the CPU must be held in reset.
- `done`  out  1  one-cycle pulse: the frame loaded and the checksum matched.
- `error`  out  1  one-cycle pulse: the frame was rejected.
- `loaded_count`  out  `ADDR+1`  number of commands written by the current or last frame.

## Operation
- A byte transfers on a rising edge where `in_valid && in_ready` is true.
- Frame format:
  - header `8'hA5`;
  - length `N`;
  - `N` commands of `BYTES` bytes each, least-significant byte first;
  - checksum byte equal to the XOR of all command bytes (header and length are excluded).
- States:
  - IDLE: accepts and discards any byte other than `A5`. On `A5`: go to LEN, set `cpu_hold`, clear `loaded_count`, clear the checksum accumulator.
  - LEN: if `N==0` or `N > 2**ADDR`, go to ERR. Otherwise latch `N` and go to CMD.
  - CMD: shift in bytes. After byte `BYTES`:
    - if any assembled bit at or above position `WORD` is 1, go to ERR;
    - otherwise go to WRITE.
  - WRITE: for one cycle, `prog_write=1`, `prog_addr=loaded_count[ADDR-1:0]`, `prog_cmd=` the assembled word. Then increment `loaded_count`. Go to SUM if `loaded_count+1==N`, otherwise to CMD.
  - SUM: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE: pulse `done`, clear `cpu_hold`, go to IDLE.
  - ERR: pulse `error`, go to IDLE. `cpu_hold` stays high.
- `cpu_hold` clears only through DONE or `reset`. A failed or truncated load therefore never releases the CPU onto a partially written program.
- Bytes written before an error remain in text RAM. They are not rolled back.
- The checksum accumulator XORs every command byte as it is accepted.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready=1`;
  - `prog_write=0`, `prog_addr=0`, `prog_cmd=0`;
  - `cpu_hold=0`, `done=0`, `error=0`, `loaded_count=0`.
- `in_ready` is 1 in IDLE, LEN, CMD and SUM, and 0 in WRITE, DONE and ERR. Each of those three states lasts exactly one cycle.
- Write latency: `prog_write` is high in the cycle after the edge that accepted the last byte of a command.
- `prog_addr` and `prog_cmd` hold their last written values outside WRITE.
- `done` and `error` are high in the cycle after the edge that accepted the checksum byte (or the offending byte). They are never high together.
- Peak rate: one command per `BYTES+1` cycles.
- `in_valid` low stalls any state indefinitely. There is no timeout.
- `reset` asserted in any state:
  - returns to the reset values on the next edge;
  - any `prog_write` due in that cycle is suppressed by reset;
  - `cpu_hold` drops to 0.
- An `A5` byte arriving mid-frame is treated as data, not as a resynchronising header.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum `loader_state_t` (IDLE, LEN, CMD, WRITE, SUM, DONE, ERR);
  - constant `LOADER_HEADER = 8'hA5`.
- One sub-module, `cmd_assembler`:
  - shifts in bytes, counts to `BYTES`, and flags completion;
  - flags overflow when an assembled bit at or above position `WORD` is 1.
- The top level owns the FSM, the checksum accumulator and `loaded_count`.

## Test plan
- Two-command load, defaults: send `A5 02 12 03 FF 0C E2`.
  - Writes `addr0=12'h312` and `addr1=12'hCFF`.
  - `done` pulses; `cpu_hold` rises after `A5` and falls after `done`; `loaded_count=2`.
- Bad checksum: same frame with final byte `E3`.
  - Both writes still occur; `error` pulses, `done` stays low, `cpu_hold` stays 1.
  - A following good frame then clears `cpu_hold`.
- Overflow: send `A5 01 00 10`.
  - Bit 12 set, so `error` pulses with no `prog_write`.
- Zero length: `A5 00` → `error` in the next cycle.
- Leading garbage and stalls: `00 5A A5 01 34 08 3C` with `in_valid` toggling every other cycle.
  - Single write `addr0=12'h834`, then `done`.
  - `in_ready` is low exactly in the WRITE and DONE cycles.
- Reset mid-frame: assert `reset` after `A5 02 12`.
  - Outputs return to reset values and no write occurs.
  - A complete frame sent after reset loads normally.
